wb_master_engine: RTL and testbench

WB_MASTER_ENGINE -- requirements
Module: wb_master_engine

---
 rtl/wb_master_engine_pkg.sv | 34 +++
 rtl/wb_master_engine_if.sv | 54 +++++
 rtl/wb_timeout_cnt.sv | 31 +++
 rtl/wb_master_engine.sv | 132 +++++++++++++
 tb/tb_wb_master_engine.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_engine_pkg.sv
// Shared definitions for the single-transfer Wishbone master engine:
// default geometry, FSM state encoding, request/response records and helpers.
package wb_master_engine_pkg;

  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 12;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RSP    = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [AW_DEF-1:0]     adr;
    logic [DW_DEF-1:0]     dat;
    logic [DW_DEF/8-1:0]   sel;
  } wb_req_t;

  typedef struct packed {
    logic [DW_DEF-1:0] dat;
    logic              err;
    logic              tmo;
  } wb_rsp_t;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/wb_master_engine_if.sv
// Request, response and Wishbone bus signals of the master engine.
// The master modport is the engine's view; slave is the surrounding system.
interface wb_master_engine_if
  import wb_master_engine_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  localparam int SW  = DW / 8;
  localparam int OFS = $clog2(SW);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [AW-1:0]     req_adr_i;
  logic [DW-1:0]     req_dat_i;
  logic [SW-1:0]     req_sel_i;
  logic              req_lock_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DW-1:0]     rsp_dat_o;
  logic              rsp_err_o;
  logic              rsp_tmo_o;

  logic [AW-OFS-1:0] wb_adr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [SW-1:0]     wb_sel_o;
  logic              wb_we_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [DW-1:0]     wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, req_lock_i,
    output req_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
    input  rsp_ready_i,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, req_lock_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
    output rsp_ready_i,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Counts consecutive enabled cycles; expired is high on the TIMEOUT-th one,
// so the owner can abandon the bus cycle at that edge.
module wb_timeout_cnt
  import wb_master_engine_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;

  assign expired = enable && (cnt_r == CW'(TIMEOUT - 1));

  // Cycle counter, held at its last value once expired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/wb_master_engine.sv
// Single-outstanding Wishbone classic master: takes one request, runs one bus
// cycle with ack/err/timeout termination and optional cyc lock, returns one response.
module wb_master_engine
  import wb_master_engine_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  wb_master_engine_if.master   bus,
  output logic                 busy_o,
  output logic [15:0]          err_cnt_o
);
  localparam int SW  = DW / 8;
  localparam int OFS = $clog2(SW);

  wb_state_e         state_r;
  logic [AW-OFS-1:0] wb_adr_r;
  logic [DW-1:0]     wb_dat_r;
  logic [SW-1:0]     wb_sel_r;
  logic              wb_we_r;
  logic              wb_cyc_r;
  logic              wb_stb_r;
  logic              lock_r;
  logic              rsp_valid_r;
  logic [DW-1:0]     rsp_dat_r;
  logic              rsp_err_r;
  logic              rsp_tmo_r;
  logic [15:0]       err_cnt_r;

  logic accept_s;
  logic term_s;
  logic active_s;
  logic expired_s;

  assign active_s = (state_r == ST_ACTIVE);
  assign accept_s = bus.req_valid_i && (state_r == ST_IDLE);
  assign term_s   = bus.wb_ack_i || bus.wb_err_i;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .enable  (active_s),
    .clear   (!active_s),
    .expired (expired_s)
  );

  // Transfer FSM; every bus and response output comes straight from a register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r     <= ST_IDLE;
      wb_adr_r    <= {(AW-OFS){1'b0}};
      wb_dat_r    <= {DW{1'b0}};
      wb_sel_r    <= {SW{1'b0}};
      wb_we_r     <= 1'b0;
      wb_cyc_r    <= 1'b0;
      wb_stb_r    <= 1'b0;
      lock_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
      rsp_tmo_r   <= 1'b0;
      err_cnt_r   <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            wb_adr_r <= bus.req_adr_i[AW-1:OFS];
            wb_dat_r <= bus.req_dat_i;
            wb_sel_r <= bus.req_sel_i;
            wb_we_r  <= bus.req_we_i;
            lock_r   <= bus.req_lock_i;
            wb_cyc_r <= 1'b1;
            wb_stb_r <= 1'b1;
            state_r  <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A slave answer on the expiry cycle still counts as a normal termination
          if (term_s) begin
            rsp_dat_r   <= wb_we_r ? {DW{1'b0}} : bus.wb_dat_i;
            rsp_err_r   <= bus.wb_err_i;
            rsp_tmo_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            wb_stb_r    <= 1'b0;
            wb_cyc_r    <= lock_r;
            state_r     <= ST_RSP;
            if (bus.wb_err_i) begin
              err_cnt_r <= sat_inc16(err_cnt_r);
            end
          end else if (expired_s) begin
            rsp_dat_r   <= {DW{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_tmo_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            wb_stb_r    <= 1'b0;
            wb_cyc_r    <= 1'b0;
            lock_r      <= 1'b0;
            state_r     <= ST_RSP;
            err_cnt_r   <= sat_inc16(err_cnt_r);
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = (state_r == ST_IDLE);
  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_dat_o   = rsp_dat_r;
  assign bus.rsp_err_o   = rsp_err_r;
  assign bus.rsp_tmo_o   = rsp_tmo_r;
  assign bus.wb_adr_o    = wb_adr_r;
  assign bus.wb_dat_o    = wb_dat_r;
  assign bus.wb_sel_o    = wb_sel_r;
  assign bus.wb_we_o     = wb_we_r;
  assign bus.wb_cyc_o    = wb_cyc_r;
  assign bus.wb_stb_o    = wb_stb_r;
  assign busy_o          = (state_r != ST_IDLE);
  assign err_cnt_o       = err_cnt_r;

endmodule

// File: tb/tb_wb_master_engine.sv
// Bench for wb_master_engine: directed vector table, lock/stray/reset sequences,
// then random transfers scored against a transaction-level reference model.
module tb_wb_master_engine;
  import wb_master_engine_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        busy;
  logic [15:0] err_cnt;

  wb_master_engine_if #(.DW(DW), .AW(AW)) bus();

  wb_master_engine #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus.master),
    .busy_o     (busy),
    .err_cnt_o  (err_cnt)
  );

  // Behavioural slave: answers on its (slv_wait+1)-th strobe cycle; -1 = never
  logic        slv_ack = 1'b0, slv_err = 1'b0, stray_ack = 1'b0, stray_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          slv_wait = 0;
  bit          slv_use_err = 1'b0, slv_use_both = 1'b0;
  int          stb_seen = 0;

  assign bus.wb_ack_i = slv_ack | stray_ack;
  assign bus.wb_err_i = slv_err | stray_err;
  assign bus.wb_dat_i = slv_rdata;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.wb_stb_o) begin
        if (stb_seen == slv_wait) begin
          slv_ack = !slv_use_err || slv_use_both;
          slv_err = slv_use_err || slv_use_both;
        end else begin
          slv_ack = 1'b0;
          slv_err = 1'b0;
        end
        stb_seen++;
      end else begin
        stb_seen = 0;
        slv_ack  = 1'b0;
        slv_err  = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_err_cnt = 16'h0;
  bit          model_cyc   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wb_req_t mk_req(input logic we, input logic lock, input logic [11:0] adr,
                                     input logic [31:0] dat, input logic [3:0] sel);
    wb_req_t r;
    r.we = we; r.lock = lock; r.adr = adr; r.dat = dat; r.sel = sel;
    return r;
  endfunction

  // Runs one transfer end to end; checks bus stability while strobing and response stability while stalled
  task automatic do_xfer(input wb_req_t r, input int wait_c, input bit e, input bit both,
                         input logic [31:0] rd, input int rsp_delay,
                         output int stb_n, output int lat, output logic [31:0] o_dat,
                         output bit o_err, output bit o_tmo, output bit o_cyc_rsp, output bit o_cyc_after);
    int n;
    slv_wait = wait_c; slv_use_err = e; slv_use_both = both; slv_rdata = rd;
    bus.req_valid_i = 1'b1; bus.req_we_i = r.we; bus.req_adr_i = r.adr;
    bus.req_dat_i = r.dat; bus.req_sel_i = r.sel; bus.req_lock_i = r.lock;
    check("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_dat_i = 32'h0; bus.req_adr_i = 12'h0; bus.req_sel_i = 4'h0;
    stb_n = 0;
    n = 0;
    while (!bus.rsp_valid_o && n < 40) begin
      if (bus.wb_stb_o) begin
        stb_n++;
        check("wb_adr", 64'(bus.wb_adr_o), 64'(r.adr >> 2));
        check("wb_dat", 64'(bus.wb_dat_o), 64'(r.dat));
        check("wb_sel", 64'(bus.wb_sel_o), 64'(r.sel));
        check("wb_we",  64'(bus.wb_we_o),  64'(r.we));
        check("wb_cyc_with_stb", 64'(bus.wb_cyc_o), 64'd1);
      end
      check("busy_active", 64'(busy), 64'd1);
      @(posedge clk); #1;
      n++;
    end
    check("rsp_within_bound", 64'(bus.rsp_valid_o), 64'd1);
    lat = n + 1;
    o_dat = bus.rsp_dat_o; o_err = bus.rsp_err_o; o_tmo = bus.rsp_tmo_o;
    o_cyc_rsp = bus.wb_cyc_o;
    check("stb_low_in_rsp", 64'(bus.wb_stb_o), 64'd0);
    for (int k = 0; k < rsp_delay; k++) begin
      @(posedge clk); #1;
      check("rsp_hold_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("rsp_hold_dat",   64'(bus.rsp_dat_o),   64'(o_dat));
      check("rsp_hold_err",   64'(bus.rsp_err_o),   64'(o_err));
      check("rsp_hold_tmo",   64'(bus.rsp_tmo_o),   64'(o_tmo));
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    check("rsp_valid_cleared", 64'(bus.rsp_valid_o), 64'd0);
    check("req_ready_after",   64'(bus.req_ready_o), 64'd1);
    o_cyc_after = bus.wb_cyc_o;
  endtask

  typedef struct {
    wb_req_t     req;
    int          wait_c;
    bit          e;
    bit          both;
    logic [31:0] rd;
    int          rsp_delay;
    int          exp_stb;
    int          exp_lat;
    logic [31:0] exp_dat;
    bit          exp_err;
    bit          exp_tmo;
    bit          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          stb_n, lat;
    logic [31:0] o_dat;
    bit          o_err, o_tmo, o_cyc_rsp, o_cyc_after;

    vecs[0] = '{mk_req(1'b0, 1'b0, 12'h404, 32'h0,        4'hF), 0, 1'b0, 1'b0, 32'hDEADBEEF, 0,  1, 2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{mk_req(1'b1, 1'b0, 12'h0A8, 32'h12345678, 4'h3), 5, 1'b0, 1'b0, 32'hCAFEF00D, 1,  6, 7, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[2] = '{mk_req(1'b0, 1'b0, 12'h7FC, 32'h0,        4'hF), -1, 1'b0, 1'b0, 32'h11111111, 0, 8, 9, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[3] = '{mk_req(1'b0, 1'b0, 12'h010, 32'h0,        4'hF), 7, 1'b0, 1'b0, 32'h13579BDF, 0,  8, 9, 32'h13579BDF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{mk_req(1'b0, 1'b0, 12'h020, 32'h0,        4'hC), 2, 1'b1, 1'b0, 32'h0BADF00D, 2,  3, 4, 32'h0BADF00D, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{mk_req(1'b1, 1'b0, 12'h030, 32'hA5A5A5A5, 4'hF), 1, 1'b0, 1'b1, 32'h22222222, 10, 2, 3, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[6] = '{mk_req(1'b1, 1'b1, 12'h040, 32'h5A5A5A5A, 4'hF), -1, 1'b0, 1'b0, 32'h33333333, 0, 8, 9, 32'h0,        1'b1, 1'b1, 1'b0};

    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_adr_i = 12'h0; bus.req_dat_i = 32'h0;
    bus.req_sel_i = 4'h0; bus.req_lock_i = 1'b0; bus.rsp_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("rst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_adr", 64'(bus.wb_adr_o), 64'd0);
    check("rst_dat", 64'(bus.wb_dat_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      do_xfer(vecs[i].req, vecs[i].wait_c, vecs[i].e, vecs[i].both, vecs[i].rd, vecs[i].rsp_delay,
              stb_n, lat, o_dat, o_err, o_tmo, o_cyc_rsp, o_cyc_after);
      if (vecs[i].exp_err) exp_err_cnt++;
      check($sformatf("v%0d_stb_cycles", i), 64'(stb_n), 64'(vecs[i].exp_stb));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_rsp_dat", i), 64'(o_dat), 64'(vecs[i].exp_dat));
      check($sformatf("v%0d_rsp_err", i), 64'(o_err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_rsp_tmo", i), 64'(o_tmo), 64'(vecs[i].exp_tmo));
      check($sformatf("v%0d_cyc_rsp", i), 64'(o_cyc_rsp), 64'(vecs[i].exp_cyc));
      check($sformatf("v%0d_cyc_after", i), 64'(o_cyc_after), 64'(vecs[i].exp_cyc));
      check($sformatf("v%0d_err_cnt", i), 64'(err_cnt), 64'(exp_err_cnt));
    end

    // Locked pair: cyc stays high from first strobe through the second termination
    do_xfer(mk_req(1'b0, 1'b1, 12'h100, 32'h0, 4'hF), 1, 1'b0, 1'b0, 32'h44444444, 1,
            stb_n, lat, o_dat, o_err, o_tmo, o_cyc_rsp, o_cyc_after);
    check("lock1_cyc_rsp", 64'(o_cyc_rsp), 64'd1);
    check("lock1_cyc_after", 64'(o_cyc_after), 64'd1);
    check("lock1_dat", 64'(o_dat), 64'h44444444);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("lock_gap_cyc", 64'(bus.wb_cyc_o), 64'd1);
      check("lock_gap_stb", 64'(bus.wb_stb_o), 64'd0);
    end
    do_xfer(mk_req(1'b0, 1'b0, 12'h104, 32'h0, 4'hF), 2, 1'b0, 1'b0, 32'h55555555, 0,
            stb_n, lat, o_dat, o_err, o_tmo, o_cyc_rsp, o_cyc_after);
    check("lock2_cyc_rsp", 64'(o_cyc_rsp), 64'd0);
    check("lock2_cyc_after", 64'(o_cyc_after), 64'd0);
    check("lock2_stb_cycles", 64'(stb_n), 64'd3);

    // Stray ack/err while idle must be ignored
    stray_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) stray_err = 1'b1;
      check("stray_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      check("stray_busy", 64'(busy), 64'd0);
    end
    stray_ack = 1'b0; stray_err = 1'b0;
    @(posedge clk); #1;
    check("stray_err_cnt", 64'(err_cnt), 64'(exp_err_cnt));

    // Random transfers against the transaction model
    for (int t = 0; t < 40; t++) begin
      wb_req_t     r;
      int          w, dly, gap, m_stb;
      bit          e, both, m_err, m_tmo;
      logic [31:0] rd, m_dat;
      r    = mk_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    12'($urandom_range(0, 4095)), 32'($urandom), 4'($urandom_range(0, 15)));
      w    = int'($urandom_range(0, 10));
      e    = ($urandom_range(0, 3) == 0);
      both = ($urandom_range(0, 5) == 0);
      rd   = 32'($urandom);
      dly  = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        @(posedge clk); #1;
        check("rnd_gap_cyc", 64'(bus.wb_cyc_o), 64'(model_cyc));
      end
      if (w < TMO) begin
        m_stb = w + 1; m_tmo = 1'b0; m_err = e || both;
        m_dat = r.we ? 32'h0 : rd; model_cyc = r.lock;
      end else begin
        m_stb = TMO; m_tmo = 1'b1; m_err = 1'b1; m_dat = 32'h0; model_cyc = 1'b0;
      end
      if (m_err && exp_err_cnt != 16'hFFFF) exp_err_cnt++;
      do_xfer(r, w, e, both, rd, dly, stb_n, lat, o_dat, o_err, o_tmo, o_cyc_rsp, o_cyc_after);
      check("rnd_stb_cycles", 64'(stb_n), 64'(m_stb));
      check("rnd_latency", 64'(lat), 64'(m_stb + 1));
      if (!m_tmo) check("rnd_rsp_dat", 64'(o_dat), 64'(m_dat));
      check("rnd_rsp_err", 64'(o_err), 64'(m_err));
      check("rnd_rsp_tmo", 64'(o_tmo), 64'(m_tmo));
      check("rnd_cyc_after", 64'(o_cyc_after), 64'(model_cyc));
      check("rnd_err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
    end

    // Reset in the middle of a stalled transfer
    slv_wait = -1;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_adr_i = 12'h200; bus.req_lock_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    check("mid_stb_before_rst", 64'(bus.wb_stb_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("mid_rst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("post_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      check("post_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
      check("post_rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
